mem_stage_ctrl: RTL and testbench

Memory-stage controller of the 5-stage pipeline, directly downstream of the EtoM register. It consumes the M-stage control and data bundle and runs word loads/stores on a variable-latency data-memory port with a req/ack handshake. It raises a pipeline stall while an access is outstanding and resolves the branch decision. It also drives the MtoW register, and flags misaligned or timed-out accesses.

---
 rtl/mem_stage_ctrl.sv | 102 ++++++++++
 tb/tb_mem_stage_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues word loads/stores on a req/ack data port,
// stalls the front of the pipeline while an access is outstanding, and drives MtoW.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rfweM,
    input  logic        mtorfselM,
    input  logic        dmweM,
    input  logic        branchM,
    input  logic        zeroM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] dmdinM,
    input  logic [4:0]  rtdM,
    output logic        pcsrcM,
    output logic        stallM,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        rfweW,
    output logic        mtorfselW,
    output logic [31:0] aluoutW,
    output logic [31:0] dmdoutW,
    output logic [4:0]  rtdW,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state;
    logic [TO_W-1:0] toCnt;
    logic            memop, aligned, misaligned, timeout, done;

    assign memop      = dmweM | mtorfselM;
    assign aligned    = (aluoutM[1:0] == 2'b00);
    assign misaligned = memop & ~aligned;
    // An ack on the final counted cycle still wins over the abort.
    assign timeout    = (state == BUSY) && (toCnt == TO_W'(TIMEOUT_CYCLES)) && !dm_ack;

    // Gated by rst_n so the request drops the instant reset asserts, even
    // while the upstream bundle still presents a memory op.
    assign dm_req   = rst_n && ((state == IDLE) ? (memop && aligned) : !timeout);
    assign done     = dm_req & dm_ack;
    assign stallM   = dm_req & ~dm_ack;
    assign dm_we    = dmweM & dm_req;
    assign dm_addr  = aluoutM;
    assign dm_wdata = dmdinM;
    assign pcsrcM   = branchM & zeroM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            toCnt        <= '0;
            rfweW        <= 1'b0;
            mtorfselW    <= 1'b0;
            aluoutW      <= '0;
            dmdoutW      <= '0;
            rtdW         <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    toCnt <= '0;
                    if (stallM) state <= BUSY;
                end
                BUSY: begin
                    if (done || timeout) begin
                        state <= IDLE;
                        toCnt <= '0;
                    end else begin
                        toCnt <= toCnt + TO_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    toCnt <= '0;
                end
            endcase

            if (misaligned) misalign_err <= 1'b1;
            if (timeout)    bus_err      <= 1'b1;

            if (stallM) begin
                rfweW <= 1'b0;
            end else begin
                rfweW     <= rfweM & ~misaligned & ~timeout;
                mtorfselW <= mtorfselM;
                aluoutW   <= aluoutM;
                rtdW      <= rtdM;
                if (done && mtorfselM) dmdoutW <= dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: access-age scoreboard model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_stage_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rfweM = 1'b0, mtorfselM = 1'b0, dmweM = 1'b0, branchM = 1'b0, zeroM = 1'b0;
    logic [31:0] aluoutM = '0, dmdinM = '0, dm_rdata = '0;
    logic [4:0]  rtdM = '0;
    logic        dm_ack = 1'b0;
    logic        pcsrcM, stallM, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, aluoutW, dmdoutW;
    logic        rfweW, mtorfselW, misalign_err, bus_err;
    logic [4:0]  rtdW;

    int vectors = 0;
    int miscompares = 0;
    logic checkEn = 1'b0;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rfweM(rfweM), .mtorfselM(mtorfselM), .dmweM(dmweM), .branchM(branchM), .zeroM(zeroM),
        .aluoutM(aluoutM), .dmdinM(dmdinM), .rtdM(rtdM),
        .pcsrcM(pcsrcM), .stallM(stallM),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .rfweW(rfweW), .mtorfselW(mtorfselW), .aluoutW(aluoutW), .dmdoutW(dmdoutW), .rtdW(rtdW),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an access is "live" while an aligned memop is presented; its age counts
    // cycles since issue. It may wait TO cycles in BUSY; at age TO+1 without ack it aborts.
    int          age = 0;
    logic        mRfweW = 1'b0, mMtorfselW = 1'b0, mMisErr = 1'b0, mBusErr = 1'b0;
    logic [31:0] mAluoutW = '0, mDmdoutW = '0;
    logic [4:0]  mRtdW = '0;
    logic        eActive, eAborted, eReq, eStall, eDone, eMis, eMemop;

    always_comb begin
        eMemop   = dmweM || mtorfselM;
        eMis     = eMemop && (aluoutM[1:0] != 2'b00);
        eActive  = rst_n && eMemop && !eMis;
        eAborted = eActive && (age > TO) && !dm_ack;
        eReq     = eActive && !eAborted;
        eStall   = eReq && !dm_ack;
        eDone    = eReq && dm_ack;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age        <= 0;
            mRfweW     <= 1'b0;
            mMtorfselW <= 1'b0;
            mAluoutW   <= '0;
            mDmdoutW   <= '0;
            mRtdW      <= '0;
            mMisErr    <= 1'b0;
            mBusErr    <= 1'b0;
        end else begin
            age <= (eActive && !eDone && !eAborted) ? age + 1 : 0;
            if (eMis && rst_n) mMisErr <= 1'b1;
            if (eAborted)      mBusErr <= 1'b1;
            if (eStall) begin
                mRfweW <= 1'b0;
            end else begin
                mRfweW     <= rfweM && !eMis && !eAborted;
                mMtorfselW <= mtorfselM;
                mAluoutW   <= aluoutM;
                mRtdW      <= rtdM;
                if (eDone && mtorfselM) mDmdoutW <= dm_rdata;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            chk1("pcsrcM", pcsrcM, branchM && zeroM);
            chk1("dm_req", dm_req, eReq);
            chk1("stallM", stallM, eStall);
            chk1("dm_we", dm_we, eReq && dmweM);
            chk32("dm_addr", dm_addr, aluoutM);
            chk32("dm_wdata", dm_wdata, dmdinM);
            chk1("rfweW", rfweW, mRfweW);
            chk1("mtorfselW", mtorfselW, mMtorfselW);
            chk32("aluoutW", aluoutW, mAluoutW);
            chk32("dmdoutW", dmdoutW, mDmdoutW);
            chk32("rtdW", {27'd0, rtdW}, {27'd0, mRtdW});
            chk1("misalign_err", misalign_err, mMisErr);
            chk1("bus_err", bus_err, mBusErr);
        end
    end

    task automatic clr();
        rfweM = 1'b0; mtorfselM = 1'b0; dmweM = 1'b0; branchM = 1'b0; zeroM = 1'b0;
        aluoutM = '0; dmdinM = '0; rtdM = '0; dm_ack = 1'b0; dm_rdata = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Holds the presented access, raising ack at the given age (-1 = never),
    // until a cycle with no stall; returns the number of stalled cycles.
    task automatic runAccess(input int ackAt, input logic [31:0] rd, output int stalls);
        logic fin;
        fin = 1'b0;
        stalls = 0;
        for (int a = 0; a < 20 && !fin; a++) begin
            dm_ack = (a == ackAt);
            dm_rdata = rd;
            #1;
            if (a >= 1) chk1("bubble_rfweW", rfweW, 1'b0);
            if (!stallM) begin
                fin = 1'b1;
            end else begin
                stalls++;
                nextCycle();
            end
        end
        if (!fin) begin
            vectors++;
            miscompares++;
            $display("FAIL access_bound: got no release expected release within 20 cycles");
        end
    endtask

    initial begin
        int st;
        clr();
        #1 rst_n = 1'b0;
        #1 checkEn = 1'b1;
        nextCycle();
        chk1("rst_rfweW", rfweW, 1'b0);
        chk32("rst_aluoutW", aluoutW, 32'h0);
        chk1("rst_bus_err", bus_err, 1'b0);
        nextCycle();

        // ALU op; a stray ack with no request must be ignored
        rst_n = 1'b1;
        rfweM = 1'b1; aluoutM = 32'h1234; rtdM = 5'd5; dm_ack = 1'b1;
        #1;
        chk1("alu_dm_req", dm_req, 1'b0);
        chk1("alu_stallM", stallM, 1'b0);
        nextCycle();
        chk1("alu_rfweW", rfweW, 1'b1);
        chk32("alu_aluoutW", aluoutW, 32'h1234);
        chk32("alu_rtdW", {27'd0, rtdW}, 32'd5);

        // Load with ack 3 cycles after request, branch taken alongside
        clr();
        rfweM = 1'b1; mtorfselM = 1'b1; aluoutM = 32'h100; rtdM = 5'd7; branchM = 1'b1; zeroM = 1'b1;
        runAccess(3, 32'hDEADBEEF, st);
        chk32("load_stall_cycles", 32'(st), 32'd3);
        chk1("load_pcsrcM", pcsrcM, 1'b1);
        nextCycle();
        chk1("load_rfweW", rfweW, 1'b1);
        chk1("load_mtorfselW", mtorfselW, 1'b1);
        chk32("load_dmdoutW", dmdoutW, 32'hDEADBEEF);
        chk32("load_rtdW", {27'd0, rtdW}, 32'd7);

        // Store with same-cycle ack
        clr();
        dmweM = 1'b1; aluoutM = 32'h200; dmdinM = 32'hCAFE; dm_ack = 1'b1;
        #1;
        chk1("st_dm_req", dm_req, 1'b1);
        chk1("st_dm_we", dm_we, 1'b1);
        chk32("st_dm_wdata", dm_wdata, 32'hCAFE);
        chk32("st_dm_addr", dm_addr, 32'h200);
        chk1("st_stallM", stallM, 1'b0);
        nextCycle();

        // Misaligned load
        clr();
        rfweM = 1'b1; mtorfselM = 1'b1; aluoutM = 32'h102; rtdM = 5'd9;
        #1;
        chk1("mis_dm_req", dm_req, 1'b0);
        chk1("mis_stallM", stallM, 1'b0);
        nextCycle();
        chk1("mis_err", misalign_err, 1'b1);
        chk1("mis_rfweW", rfweW, 1'b0);
        clr();
        rfweM = 1'b1; aluoutM = 32'h55; rtdM = 5'd3;
        nextCycle();
        chk1("mis_err_sticky", misalign_err, 1'b1);
        chk1("alu2_rfweW", rfweW, 1'b1);

        // Timeout: no ack ever
        clr();
        rfweM = 1'b1; mtorfselM = 1'b1; aluoutM = 32'h300; rtdM = 5'd4;
        runAccess(-1, 32'h0, st);
        chk32("to_stall_cycles", 32'(st), 32'd5);
        chk1("to_abort_req", dm_req, 1'b0);
        nextCycle();
        chk1("to_bus_err", bus_err, 1'b1);
        chk1("to_rfweW", rfweW, 1'b0);
        chk32("to_dmdoutW_held", dmdoutW, 32'hDEADBEEF);

        // Ack on the last counted cycle completes
        clr();
        rfweM = 1'b1; mtorfselM = 1'b1; aluoutM = 32'h304; rtdM = 5'd6;
        runAccess(5, 32'h0BADF00D, st);
        chk32("edge_stall_cycles", 32'(st), 32'd5);
        nextCycle();
        chk1("edge_rfweW", rfweW, 1'b1);
        chk32("edge_dmdoutW", dmdoutW, 32'h0BADF00D);

        // Store with wait states
        clr();
        dmweM = 1'b1; aluoutM = 32'h308; dmdinM = 32'h77; rtdM = 5'd1;
        runAccess(2, 32'hFFFF_FFFF, st);
        chk32("st2_stall_cycles", 32'(st), 32'd2);
        nextCycle();
        chk32("st2_dmdoutW_held", dmdoutW, 32'h0BADF00D);

        // Reset while BUSY
        clr();
        rfweM = 1'b1; mtorfselM = 1'b1; aluoutM = 32'h400; rtdM = 5'd8;
        nextCycle();
        nextCycle();
        #1 rst_n = 1'b0;
        #1;
        chk1("rb_dm_req", dm_req, 1'b0);
        chk1("rb_stallM", stallM, 1'b0);
        chk1("rb_rfweW", rfweW, 1'b0);
        chk32("rb_aluoutW", aluoutW, 32'h0);
        chk32("rb_dmdoutW", dmdoutW, 32'h0);
        chk32("rb_rtdW", {27'd0, rtdW}, 32'd0);
        chk1("rb_bus_err", bus_err, 1'b0);
        chk1("rb_mis_err", misalign_err, 1'b0);
        nextCycle();
        rst_n = 1'b1;
        clr();
        rfweM = 1'b1; mtorfselM = 1'b1; aluoutM = 32'h500; rtdM = 5'd10;
        runAccess(1, 32'h600DCAFE, st);
        chk32("post_rst_stalls", 32'(st), 32'd1);
        nextCycle();
        chk1("post_rst_rfweW", rfweW, 1'b1);
        chk32("post_rst_dmdoutW", dmdoutW, 32'h600DCAFE);
        chk32("post_rst_rtdW", {27'd0, rtdW}, 32'd10);

        clr();
        nextCycle();
        nextCycle();
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
